// File: rtl/fib_seq_ctrl_if.sv
// Shared-ALU request/grant bus between the Fibonacci sequencer (master) and the ALU arbiter (slave).
// The grant is same-cycle and combinational; sum and carry are valid in the grant cycle.
interface fib_seq_ctrl_if #(
    parameter int W = 16
) ();
    logic         alu_req;
    logic         alu_gnt;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_sum;
    logic         alu_carry;

    modport master (
        output alu_req, alu_op, alu_a, alu_b,
        input  alu_gnt, alu_sum, alu_carry
    );

    modport slave (
        input  alu_req, alu_op, alu_a, alu_b,
        output alu_gnt, alu_sum, alu_carry
    );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer: F(pos) in pos cycles via the borrowed ALU adder; stalls indefinitely while grant is low.
// FIB_SAT_EN: when defined, a carry abort saturates result to all-ones instead of keeping the truncated sum.
module fib_seq_ctrl #(
    parameter int         W          = 16,
    parameter int         PW         = 9,
    parameter logic [1:0] ALU_OP_ADD = 2'b00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] pos,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          ovf,
    fib_seq_ctrl_if.master alu
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  f_prev;
    logic [W-1:0]  f_curr;
    logic [PW-1:0] cnt;
    logic [PW-1:0] pos_q;
    logic [PW-1:0] cnt_inc;
    logic          accept;
    logic          step;
    logic          trivial;

    assign cnt_inc = cnt + PW'(1);
    // F(0) and F(1) are the index itself, so no ALU traffic is needed.
    assign trivial = (pos <= PW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        accept        = 1'b0;
        step          = 1'b0;
        alu.alu_req   = 1'b0;
        alu.alu_op    = 2'b00;
        alu.alu_a     = '0;
        alu.alu_b     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = trivial ? DONE : RUN;
                end
            end
            RUN: begin
                busy        = 1'b1;
                alu.alu_req = 1'b1;
                alu.alu_op  = ALU_OP_ADD;
                alu.alu_a   = f_prev;
                alu.alu_b   = f_curr;
                if (alu.alu_gnt) begin
                    step = 1'b1;
                    if (alu.alu_carry || (cnt_inc == pos_q)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_prev <= '0;
            f_curr <= '0;
            cnt    <= '0;
            pos_q  <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            pos_q  <= pos;
            f_prev <= '0;
            f_curr <= W'(1);
            cnt    <= PW'(1);
            ovf    <= 1'b0;
            if (trivial) begin
                result <= W'(pos);
            end
        end else if (step) begin
            f_prev <= f_curr;
            f_curr <= alu.alu_sum;
            cnt    <= cnt_inc;
            if (alu.alu_carry) begin
                ovf <= 1'b1;
`ifdef FIB_SAT_EN
                result <= '1;
`else
                result <= alu.alu_sum;
`endif
            end else if (cnt_inc == pos_q) begin
                result <= alu.alu_sum;
            end
        end
    end
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a combinational ALU/arbiter model and a controllable grant.
// Expected results, latencies and request counts are hand-computed Fibonacci values.
module tb_fib_seq_ctrl;
    localparam int W  = 16;
    localparam int PW = 9;

    logic          clk;
    logic          rst;
    logic          start;
    logic [PW-1:0] pos;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          ovf;
    logic          gnt_en;

    int n_chk;
    int n_fail;

    fib_seq_ctrl_if #(.W(W)) alu_bus ();

    assign alu_bus.alu_gnt = alu_bus.alu_req & gnt_en;
    assign {alu_bus.alu_carry, alu_bus.alu_sum} = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b};

    fib_seq_ctrl #(.W(W), .PW(PW), .ALU_OP_ADD(2'b00)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pos    (pos),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .alu    (alu_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a computation and follows it to the DONE cycle. Optionally withholds the
    // grant for stall_n request cycles after grant number stall_at, and optionally pokes
    // start while RUN and while DONE to prove both are ignored.
    task automatic run_fib(input string tag, input logic [PW-1:0] p, input logic [W-1:0] exp_res,
                           input logic exp_ovf, input int exp_lat, input int stall_at,
                           input int stall_n, input logic [W-1:0] stall_a,
                           input logic [W-1:0] stall_b, input bit poke);
        int cyc;
        int reqs;
        int grants;
        int stalled;
        start  = 1'b1;
        pos    = p;
        gnt_en = 1'b1;
        tick();
        start   = 1'b0;
        cyc     = 1;
        reqs    = 0;
        grants  = 0;
        stalled = 0;
        while (!done && cyc < 200) begin
            start = 1'b0;
            if (alu_bus.alu_req) begin
                if (reqs == 0) chk({tag, " alu_op"}, alu_bus.alu_op, 2'b00);
                reqs++;
                if (grants == stall_at && stalled < stall_n) begin
                    gnt_en = 1'b0;
                    stalled++;
                    chk({tag, " stall alu_a"}, alu_bus.alu_a, stall_a);
                    chk({tag, " stall alu_b"}, alu_bus.alu_b, stall_b);
                end else begin
                    gnt_en = 1'b1;
                    grants++;
                end
            end
            if (poke && cyc == 3) begin
                start = 1'b1;
                pos   = 9'd5;
            end
            tick();
            cyc++;
        end
        start  = 1'b0;
        gnt_en = 1'b1;
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " req cycles"}, reqs, exp_lat - 1);
        chk({tag, " busy in done"}, busy, 1'b1);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " ovf"}, ovf, exp_ovf);
        if (poke) begin
            start = 1'b1;
            pos   = 9'd7;
        end
        tick();
        start = 1'b0;
        chk({tag, " done pulse ends"}, done, 1'b0);
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " result held"}, result, exp_res);
    endtask

    initial begin
        logic [W-1:0] ovf_res;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        pos    = '0;
        gnt_en = 1'b1;
        #2;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 16'd0);
        chk("reset ovf", ovf, 1'b0);
        chk("reset alu_req", alu_bus.alu_req, 1'b0);
        chk("reset alu_a", alu_bus.alu_a, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        run_fib("pos10", 9'd10, 16'd55, 1'b0, 10, -1, 0, 16'd0, 16'd0, 1'b0);
        run_fib("pos0", 9'd0, 16'd0, 1'b0, 1, -1, 0, 16'd0, 16'd0, 1'b0);
        run_fib("pos1", 9'd1, 16'd1, 1'b0, 1, -1, 0, 16'd0, 16'd0, 1'b0);
        run_fib("pos24", 9'd24, 16'd46368, 1'b0, 24, -1, 0, 16'd0, 16'd0, 1'b0);
`ifdef FIB_SAT_EN
        ovf_res = 16'hFFFF;
`else
        ovf_res = 16'd9489;
`endif
        run_fib("pos25 ovf", 9'd25, ovf_res, 1'b1, 25, -1, 0, 16'd0, 16'd0, 1'b0);
        run_fib("pos6 stall", 9'd6, 16'd8, 1'b0, 9, 2, 3, 16'd1, 16'd2, 1'b0);
        run_fib("pos10 poke", 9'd10, 16'd55, 1'b0, 10, -1, 0, 16'd0, 16'd0, 1'b1);
        run_fib("pos7", 9'd7, 16'd13, 1'b0, 7, -1, 0, 16'd0, 16'd0, 1'b0);

        // Asynchronous reset in the middle of a run, away from any clock edge.
        start = 1'b1;
        pos   = 9'd10;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre-reset alu_req", alu_bus.alu_req, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("async rst alu_req", alu_bus.alu_req, 1'b0);
        chk("async rst busy", busy, 1'b0);
        chk("async rst result", result, 16'd0);
        chk("async rst ovf", ovf, 1'b0);
        #2 rst = 1'b0;
        tick();
        chk("post-rst busy", busy, 1'b0);
        chk("post-rst alu_req", alu_bus.alu_req, 1'b0);
        run_fib("pos3 after rst", 9'd3, 16'd2, 1'b0, 3, -1, 0, 16'd0, 16'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
Sequencer that computes F(pos) (F(0)=0, F(1)=1) by repeatedly borrowing the shared calculator ALU adder through a req/gnt handshake.
- Holds the two running Fibonacci terms and the iteration counter; issues ADD operations; reports the result, done and overflow.
- Sits between the command decoder (start/pos) and the ALU arbiter. Does not own the ALU.

Parameters:
W, 16, data/result width.
PW, 9, width of the pos operand.
ALU_OP_ADD, 2'b00, opcode driven on alu_op for addition.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  one-cycle request to compute F(pos); sampled only in IDLE.
pos  input  PW  Fibonacci index; captured on accepted start.
busy  output  1  high from the cycle after accepted start until DONE exits.
done  output  1  one-cycle pulse, high while the FSM is in DONE.
result  output  W  F(pos); held until the next accepted start.
ovf  output  1  result exceeded W bits; held with result.
alu_req  output  1  ALU access request.
alu_gnt  input  1  ALU grant; same-cycle, valid only while alu_req=1.
alu_op  output  2  ALU opcode; ALU_OP_ADD whenever alu_req=1, else 0.
alu_a  output  W  ALU operand A = f_prev while alu_req=1, else 0.
alu_b  output  W  ALU operand B = f_curr while alu_req=1, else 0.
alu_sum  input  W  combinational ALU sum, valid in the grant cycle.
alu_carry  input  1  ALU carry-out, valid in the grant cycle.

Behaviour:
- Reset (async, any state): FSM=IDLE; f_prev, f_curr, cnt, pos_q, result=0; ovf, busy, done, alu_req=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - pos_q<=pos, f_prev<=0, f_curr<=1, cnt<=1, ovf<=0.
  - pos<=1: go DONE with result<=pos (zero-extended).
  - Otherwise: go RUN.
- RUN:
  - alu_req=1, alu_a=f_prev, alu_b=f_curr, alu_op=ALU_OP_ADD.
  - alu_gnt=0: all registers hold; operands stay stable; no timeout.
  - alu_gnt=1: f_prev<=f_curr, f_curr<=alu_sum, cnt<=cnt+1.
  - alu_gnt=1 and alu_carry=1: ovf<=1, result<=alu_sum (low W bits), go DONE (abort).
  - alu_gnt=1 and cnt+1==pos_q: result<=alu_sum, go DONE.
- DONE: done=1, busy=1 for exactly one cycle; alu_req=0; then go IDLE.
- busy=1 in RUN and DONE.
- Latency: start accepted at cycle T.
  - pos>=2 with continuous grant: n-1 RUN cycles T+1..T+n-1; done at T+n.
  - Each withheld grant adds one cycle.
  - pos<=1: done at T+1, with zero ALU requests.
- start while busy: ignored; no state change, pos not recaptured.
- start in the DONE cycle: ignored. Only IDLE samples start.
- cnt is PW bits wide; compared for equality only, never wraps because pos_q <= 2^PW-1.
- For W=16 without overflow, max valid pos is 24 (46368). Larger pos always sets ovf.

Optional Feature:
FIB_SAT_EN
- Defined: on carry abort, result<=all-ones (16'hFFFF), ovf<=1.
- Undefined: result<=truncated alu_sum, ovf<=1.
- Abort timing and done behaviour are identical in both builds.

Test Plan:
- pos=10, alu_gnt tied 1, start at T -> 9 req cycles T+1..T+9; done at T+10; result=55; ovf=0.
- pos=0, then pos=1 -> done at T+1, result=0 then 1; alu_req never asserted.
- pos=24 -> result=46368, ovf=0. pos=25 -> ovf=1, done after the 24th grant; result=9489 (macro off) or 16'hFFFF (FIB_SAT_EN).
- pos=6 with alu_gnt low for 3 cycles after the 2nd grant -> alu_a=1, alu_b=2 held stable over the stall; result=8; done delayed exactly 3 cycles.
- pos=10 run with start pulsed in RUN and in DONE -> ignored; result=55; next IDLE start with pos=7 -> result=13.
- rst asserted mid-RUN, asynchronously between clock edges -> alu_req, busy, result, ovf drop to 0 immediately; FSM in IDLE after release; new start with pos=3 -> result=2.
